// File: rtl/opcode_fetch_if.sv
// Handshake/bus bundle for opcode_fetch: fetch controls and interrupt pins in,
// selected and registered opcode/source out.
interface opcode_fetch_if;
    logic       enableFFs;
    logic       getInstruction;
    logic [7:0] dataBus;
    logic       nmi_n;
    logic       irq_n;
    logic       interruptMask;
    logic [7:0] nextOpcode;
    logic [2:0] nextSource;
    logic [7:0] opcodeReg;
    logic [2:0] intSource;
    logic       pcHold;
    logic       nmiAck;

    modport master (
        output enableFFs, getInstruction, dataBus, nmi_n, irq_n, interruptMask,
        input  nextOpcode, nextSource, opcodeReg, intSource, pcHold, nmiAck
    );

    modport slave (
        input  enableFFs, getInstruction, dataBus, nmi_n, irq_n, interruptMask,
        output nextOpcode, nextSource, opcodeReg, intSource, pcHold, nmiAck
    );
endinterface

// File: rtl/opcode_fetch.sv
// Opcode fetch front end: interrupt sync/prioritisation and forced-BRK injection.
// Optional macro BRK_SOFT_INT_EN reports a fetched BRK opcode as source 4.
module opcode_fetch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  BRK_OPCODE  = 8'h00
) (
    input  logic           clk,
    input  logic           rst,
    opcode_fetch_if.slave  bus
);

    typedef enum logic [2:0] {
        SRC_NONE  = 3'd0,
        SRC_IRQ   = 3'd1,
        SRC_NMI   = 3'd2,
        SRC_RESET = 3'd3,
        SRC_BRK   = 3'd4
    } src_e;

    logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
    logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
    logic                   nmi_prev_q, nmi_prev_d;
    logic                   rst_pending_q, rst_pending_d;
    logic                   nmi_pending_q, nmi_pending_d;
    logic [7:0]             opcode_q, opcode_d;
    src_e                   int_source_q, int_source_d;
    logic                   pc_hold_q, pc_hold_d;
    logic                   nmi_ack_q, nmi_ack_d;

    logic                   fetch;
    logic                   nmi_synced;
    logic                   irq_synced;
    logic                   nmi_fall;
    logic                   irq_req;
    logic                   injected;
    src_e                   next_source;
    logic [7:0]             next_opcode;

    always_comb begin
        fetch      = bus.getInstruction & bus.enableFFs;
        nmi_synced = nmi_sync_q[SYNC_STAGES-1];
        irq_synced = irq_sync_q[SYNC_STAGES-1];
        nmi_sync_d = {nmi_sync_q[SYNC_STAGES-2:0], bus.nmi_n};
        irq_sync_d = {irq_sync_q[SYNC_STAGES-2:0], bus.irq_n};
        nmi_prev_d = nmi_synced;
        nmi_fall   = nmi_prev_q & ~nmi_synced;
        irq_req    = ~irq_synced & ~bus.interruptMask;

        next_source = SRC_NONE;
        if (rst_pending_q)      next_source = SRC_RESET;
        else if (nmi_pending_q) next_source = SRC_NMI;
        else if (irq_req)       next_source = SRC_IRQ;
`ifdef BRK_SOFT_INT_EN
        else if (bus.dataBus == BRK_OPCODE) next_source = SRC_BRK;
`endif
        injected    = (next_source == SRC_RESET) || (next_source == SRC_NMI) ||
                      (next_source == SRC_IRQ);
        next_opcode = injected ? BRK_OPCODE : bus.dataBus;

        opcode_d      = fetch ? next_opcode : opcode_q;
        int_source_d  = fetch ? next_source : int_source_q;
        pc_hold_d     = fetch ? injected    : pc_hold_q;
        nmi_ack_d     = fetch && (next_source == SRC_NMI);
        rst_pending_d = rst_pending_q & ~(fetch && (next_source == SRC_RESET));
        // A fresh edge arriving on the clearing fetch must stay pending.
        nmi_pending_d = nmi_fall | (nmi_pending_q & ~(fetch && (next_source == SRC_NMI)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            nmi_sync_q    <= '1;
            irq_sync_q    <= '1;
            nmi_prev_q    <= 1'b1;
            rst_pending_q <= 1'b1;
            nmi_pending_q <= 1'b0;
            opcode_q      <= '0;
            int_source_q  <= SRC_NONE;
            pc_hold_q     <= 1'b0;
            nmi_ack_q     <= 1'b0;
        end else begin
            nmi_sync_q    <= nmi_sync_d;
            irq_sync_q    <= irq_sync_d;
            nmi_prev_q    <= nmi_prev_d;
            rst_pending_q <= rst_pending_d;
            nmi_pending_q <= nmi_pending_d;
            opcode_q      <= opcode_d;
            int_source_q  <= int_source_d;
            pc_hold_q     <= pc_hold_d;
            nmi_ack_q     <= nmi_ack_d;
        end
    end

    assign bus.nextOpcode = next_opcode;
    assign bus.nextSource = next_source;
    assign bus.opcodeReg  = opcode_q;
    assign bus.intSource  = int_source_q;
    assign bus.pcHold     = pc_hold_q;
    assign bus.nmiAck     = nmi_ack_q;

endmodule

// File: tb/tb_opcode_fetch.sv
// Scoreboard bench for opcode_fetch: driver queues expected fetch results,
// a negedge monitor checks combinational and registered outputs.
module tb_opcode_fetch;

    typedef struct {
        logic [7:0] op;
        logic [2:0] src;
        logic       hold;
        logic       ack;
    } exp_t;

`ifdef BRK_SOFT_INT_EN
    localparam logic [2:0] SOFT_BRK_SRC = 3'd4;
`else
    localparam logic [2:0] SOFT_BRK_SRC = 3'd0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    opcode_fetch_if bus ();

    opcode_fetch #(.SYNC_STAGES(2), .BRK_OPCODE(8'h00)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: registered results one negedge after a fetch, hold/ack-low otherwise.
    logic       post;
    exp_t       cur;
    logic [7:0] h_op;
    logic [2:0] h_src;
    logic       h_hold;

    initial begin
        post   = 1'b0;
        h_op   = 8'h00;
        h_src  = 3'd0;
        h_hold = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            post   = 1'b0;
            h_op   = 8'h00;
            h_src  = 3'd0;
            h_hold = 1'b0;
        end else begin
            if (post) begin
                check("opcodeReg", {24'd0, bus.opcodeReg}, {24'd0, cur.op});
                check("intSource", {29'd0, bus.intSource}, {29'd0, cur.src});
                check("pcHold", {31'd0, bus.pcHold}, {31'd0, cur.hold});
                check("nmiAck", {31'd0, bus.nmiAck}, {31'd0, cur.ack});
                h_op   = cur.op;
                h_src  = cur.src;
                h_hold = cur.hold;
                post   = 1'b0;
            end else begin
                check("opcodeReg_hold", {24'd0, bus.opcodeReg}, {24'd0, h_op});
                check("intSource_hold", {29'd0, bus.intSource}, {29'd0, h_src});
                check("pcHold_hold", {31'd0, bus.pcHold}, {31'd0, h_hold});
                check("nmiAck_idle", {31'd0, bus.nmiAck}, 32'd0);
            end
            if (bus.getInstruction && bus.enableFFs) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetch", 32'd1, 32'd0);
                end else begin
                    cur = exp_q.pop_front();
                    check("nextOpcode", {24'd0, bus.nextOpcode}, {24'd0, cur.op});
                    check("nextSource", {29'd0, bus.nextSource}, {29'd0, cur.src});
                    post = 1'b1;
                end
            end
        end
    end

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic fetch(input logic [7:0] data, input logic [7:0] op, input logic [2:0] src,
                         input logic hold, input logic ack);
        exp_t e;
        e.op   = op;
        e.src  = src;
        e.hold = hold;
        e.ack  = ack;
        exp_q.push_back(e);
        bus.dataBus        = data;
        bus.getInstruction = 1'b1;
        step(1);
        bus.getInstruction = 1'b0;
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        bus.enableFFs      = 1'b1;
        bus.getInstruction = 1'b0;
        bus.dataBus        = 8'h00;
        bus.nmi_n          = 1'b1;
        bus.irq_n          = 1'b1;
        bus.interruptMask  = 1'b1;
        step(2);
        rst = 1'b0;

        check("reset_opcodeReg", {24'd0, bus.opcodeReg}, 32'd0);
        check("reset_intSource", {29'd0, bus.intSource}, 32'd0);
        check("reset_pcHold", {31'd0, bus.pcHold}, 32'd0);
        check("reset_nmiAck", {31'd0, bus.nmiAck}, 32'd0);

        // Reset injection then normal fetch
        fetch(8'hA9, 8'h00, 3'd3, 1'b1, 1'b0);
        fetch(8'hA9, 8'hA9, 3'd0, 1'b0, 1'b0);

        // NMI edge: pending three edges after the fall, no re-trigger while held
        bus.nmi_n = 1'b0;
        step(3);
        fetch(8'hEA, 8'h00, 3'd2, 1'b1, 1'b1);
        step(1);
        fetch(8'hEA, 8'hEA, 3'd0, 1'b0, 1'b0);
        bus.nmi_n = 1'b1;

        // IRQ masked, then unmasked
        bus.irq_n = 1'b0;
        step(2);
        fetch(8'h18, 8'h18, 3'd0, 1'b0, 1'b0);
        bus.interruptMask = 1'b0;
        fetch(8'h55, 8'h00, 3'd1, 1'b1, 1'b0);
        bus.irq_n = 1'b1;
        bus.interruptMask = 1'b1;
        step(3);

        // NMI beats IRQ, IRQ follows
        bus.irq_n = 1'b0;
        bus.interruptMask = 1'b0;
        bus.nmi_n = 1'b0;
        step(3);
        fetch(8'hC6, 8'h00, 3'd2, 1'b1, 1'b1);
        fetch(8'hC6, 8'h00, 3'd1, 1'b1, 1'b0);
        bus.irq_n = 1'b1;
        bus.nmi_n = 1'b1;
        bus.interruptMask = 1'b1;
        step(4);

        // Stall: registers frozen, NMI still captured
        fetch(8'h33, 8'h33, 3'd0, 1'b0, 1'b0);
        bus.enableFFs = 1'b0;
        bus.getInstruction = 1'b1;
        bus.dataBus = 8'h77;
        bus.nmi_n = 1'b0;
        step(4);
        bus.getInstruction = 1'b0;
        bus.enableFFs = 1'b1;
        fetch(8'h77, 8'h00, 3'd2, 1'b1, 1'b1);
        bus.nmi_n = 1'b1;
        step(3);

        // New NMI edge coinciding with the clearing fetch stays pending
        bus.nmi_n = 1'b0;
        step(3);
        bus.nmi_n = 1'b1;
        step(3);
        bus.nmi_n = 1'b0;
        step(2);
        fetch(8'h11, 8'h00, 3'd2, 1'b1, 1'b1);
        fetch(8'h11, 8'h00, 3'd2, 1'b1, 1'b1);
        fetch(8'h11, 8'h11, 3'd0, 1'b0, 1'b0);
        bus.nmi_n = 1'b1;
        step(3);

        // Mid-instruction reset forces RESET injection on the next fetch
        fetch(8'h44, 8'h44, 3'd0, 1'b0, 1'b0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(1);
        fetch(8'h22, 8'h00, 3'd3, 1'b1, 1'b0);
        fetch(8'h22, 8'h22, 3'd0, 1'b0, 1'b0);

        // Fetched BRK opcode
        fetch(8'h00, 8'h00, SOFT_BRK_SRC, 1'b0, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step(1);
        if (exp_q.size() != 0) check("scoreboard_drain", exp_q.size(), 32'd0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opcode_fetch.md
Name: opcode_fetch

Overview:
Front end of the control path. On each instruction-fetch strobe it captures the next opcode byte from the data bus, or injects a forced BRK (0x00) when a RESET, NMI or IRQ sequence is pending. It presents the selected opcode and interrupt source both combinationally (same cycle, for the decoder feeding the timing state machine) and registered (for the rest of the instruction). It also owns NMI/IRQ synchronisation, NMI edge detection and interrupt prioritisation.

Parameters:
SYNC_STAGES, 2, flip-flop stages on nmi_n / irq_n; legal range 2..3.
BRK_OPCODE, 8'h00, opcode value injected for forced interrupt sequences.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  synchronous, active-high reset.
enableFFs  input  1  global advance enable; low = pipeline stall.
getInstruction  input  1  fetch strobe; high during the last cycle of an instruction.
dataBus  input  8  opcode byte read from memory this cycle.
nmi_n  input  1  asynchronous non-maskable interrupt request, active low, edge-triggered.
irq_n  input  1  asynchronous interrupt request, active low, level-sensitive.
interruptMask  input  1  I flag from the status register; 1 = IRQ masked.
nextOpcode  output  8  combinational: opcode selected this cycle (injected or dataBus).
nextSource  output  3  combinational: source of nextOpcode.
opcodeReg  output  8  registered opcode of the current instruction.
intSource  output  3  registered source: 0 NONE, 1 IRQ, 2 NMI, 3 RESET, 4 BRK (feature only).
pcHold  output  1  registered; 1 = current instruction is injected and the PC must not increment.
nmiAck  output  1  single-cycle pulse on the cycle after NMI injection.

Behaviour:
- fetch = getInstruction & enableFFs.
- Synchronisers: SYNC_STAGES flops per input. They reset to 1 and always clock, ignoring enableFFs.
- NMI edge: nmiFall = previous synced value 1 and current synced value 0. nmiPrev always clocks.
- rstPending: set by rst; cleared at a fetch that injects RESET.
- nmiPending: set by nmiFall regardless of enableFFs; cleared at a fetch that injects NMI.
- If nmiFall and that clear occur in the same cycle, set wins and the new edge stays pending.
- irqReq = synced irq_n == 0 & ~interruptMask. It is evaluated only in the fetch cycle and is not latched.
- Priority (combinational): rstPending > nmiPending > irqReq > none.
- nextOpcode = BRK_OPCODE if any source is selected, else dataBus. nextSource reports the selected code (0..3).
- On fetch:
  - opcodeReg <= nextOpcode.
  - intSource <= nextSource.
  - pcHold <= (nextSource != 0).
  - nmiAck <= (nextSource == 2).
- With no fetch:
  - opcodeReg, intSource and pcHold hold.
  - nmiAck <= 0.
- enableFFs low freezes every register except the synchronisers, nmiPrev and the nmiPending set path. nmiAck is forced to 0 while stalled.
- Reset values: opcodeReg 8'h00, intSource 0, pcHold 0, nmiAck 0, rstPending 1, nmiPending 0, synchroniser flops 1.
- rst asserted mid-instruction: all state returns to reset values on that edge. The next fetch always injects RESET.
- Latency:
  - nmi_n fall to nmiPending = SYNC_STAGES+1 cycles.
  - Registered outputs update on the fetch edge.
  - nextOpcode/nextSource have zero latency from dataBus and interrupt state.

Optional Feature:
BRK_SOFT_INT_EN
- Defined: when a fetch takes dataBus (no injection) and dataBus == BRK_OPCODE, nextSource = 4 and intSource <= 4; pcHold <= 0.
- Not defined: a fetched BRK reports source 0, and the encoding value 4 is never produced.

Test Plan:
1. rst 1 for 2 cycles, then getInstruction=1, dataBus=8'hA9 → nextOpcode 8'h00, nextSource 3; after edge opcodeReg 8'h00, intSource 3, pcHold 1. Next fetch with 8'hA9 → opcodeReg 8'hA9, intSource 0, pcHold 0.
2. nmi_n 1→0 held low, fetch 4 cycles later with dataBus 8'hEA → opcodeReg 8'h00, intSource 2; nmiAck high exactly 1 cycle. A second fetch while nmi_n is still low → 8'hEA, intSource 0 (no re-trigger).
3. irq_n=0, interruptMask=1, fetch 8'h18 → opcodeReg 8'h18, intSource 0. Set interruptMask=0, fetch → opcodeReg 8'h00, intSource 1.
4. NMI edge and irq_n=0 with mask 0 at the same fetch → intSource 2. Following fetch → intSource 1.
5. enableFFs=0 with getInstruction=1 and an nmi_n fall → opcodeReg unchanged, nmiAck 0. After enableFFs=1 and a fetch → intSource 2.
6. BRK_SOFT_INT_EN defined, fetch dataBus 8'h00 → intSource 4, pcHold 0. Undefined → intSource 0.
